organ_tone_gen: RTL and testbench

Parametrised keyboard tone generator for the electronic-organ experiment: seven note keys plus an octave selector produce a square wave on the speaker pin, with the played note reported for the 7-segment display. Successor to the single-octave organ: it adds input synchronisation and debounce, deterministic multi-key priority, three octaves, glitch-free note changes and a clean note-off. It sits between the board keys/switches and the speaker and display drivers.

---
 rtl/organ_tone_gen.sv | 194 +++++++++++++++++++
 tb/tb_organ_tone_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/organ_tone_gen.sv
// organ_tone_gen: seven-key, three-octave square-wave tone generator.
// The key, octave and enable inputs are synchronised and the key/octave
// vector is debounced. The lowest pressed key wins. A three-state
// sequencer (IDLE/RUN/STOP) does two things: it always completes the
// current half-period, and it always ends a note on a low level.
module organ_tone_gen #(
    parameter int CNT_W      = 12,
    parameter int DEB_CYCLES = 10000,
    parameter int DEB_W      = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] key_i,
    input  logic [1:0] octave_i,
    input  logic       enable_i,
    output logic       speaker_o,
    output logic [2:0] num_show_o,
    output logic [1:0] oct_show_o,
    output logic       active_o
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // synchroniser stages
    logic [6:0] key_s1_q, key_s2_q;
    logic [1:0] oct_s1_q, oct_s2_q;
    logic       en_s1_q, en_s2_q;

    // debounce state
    logic [8:0]       vec_prev_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [6:0]       acc_key_q;
    logic [1:0]       acc_oct_q;
    logic             accept;

    // note selection
    logic [2:0]       note_d;
    logic [1:0]       oct_eff;
    logic [CNT_W-1:0] base_d, half_d;

    // display / pending divisor
    logic [2:0]       num_q;
    logic [1:0]       oct_q;
    logic [CNT_W-1:0] pend_q;

    // sequencer
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tone_q;
    logic             speaker_q;
    logic             active_q;

    // Two-flop synchronisers for every asynchronous board input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q <= '0;
            key_s2_q <= '0;
            oct_s1_q <= 2'd1;
            oct_s2_q <= 2'd1;
            en_s1_q  <= 1'b0;
            en_s2_q  <= 1'b0;
        end else begin
            key_s1_q <= key_i;
            key_s2_q <= key_s1_q;
            oct_s1_q <= octave_i;
            oct_s2_q <= oct_s1_q;
            en_s1_q  <= enable_i;
            en_s2_q  <= en_s1_q;
        end
    end

    // Stable-cycle counter. The vector is accepted on the cycle the count reaches its last value.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if ({oct_s2_q, key_s2_q} != vec_prev_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_LAST) begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
        accept = ({oct_s2_q, key_s2_q} == vec_prev_q) && (deb_cnt_d == DEB_LAST);
    end

    // Debounce registers; the counter saturates once the vector has been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_prev_q <= {2'd1, 7'd0};
            deb_cnt_q  <= '0;
            acc_key_q  <= '0;
            acc_oct_q  <= 2'd1;
        end else begin
            vec_prev_q <= {oct_s2_q, key_s2_q};
            deb_cnt_q  <= deb_cnt_d;
            if (accept) begin
                acc_key_q <= key_s2_q;
                acc_oct_q <= oct_s2_q;
            end
        end
    end

    // Lowest set key wins; the octave then scales the middle-octave half-period.
    always_comb begin
        note_d = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (acc_key_q[i]) note_d = 3'(i + 1);
        end
        oct_eff = (acc_oct_q == 2'd3) ? 2'd1 : acc_oct_q;
        case (note_d)
            3'd1:    base_d = CNT_W'(1908);
            3'd2:    base_d = CNT_W'(1701);
            3'd3:    base_d = CNT_W'(1515);
            3'd4:    base_d = CNT_W'(1433);
            3'd5:    base_d = CNT_W'(1276);
            3'd6:    base_d = CNT_W'(1136);
            3'd7:    base_d = CNT_W'(1012);
            default: base_d = '0;
        endcase
        case (oct_eff)
            2'd0:    half_d = base_d << 1;
            2'd2:    half_d = base_d >> 1;
            default: half_d = base_d;
        endcase
    end

    // Register the displayed note/octave. The pending divisor is loaded only while a note is held, so STOP keeps the last D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q  <= '0;
            oct_q  <= '0;
            pend_q <= '0;
        end else begin
            num_q <= note_d;
            oct_q <= (note_d != 3'd0) ? oct_eff : 2'd0;
            if (note_d != 3'd0) pend_q <= half_d;
        end
    end

    // Tone sequencer. The speaker and active outputs are registered from the next tone/state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tone_q    <= 1'b0;
            speaker_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    tone_q    <= 1'b0;
                    speaker_q <= 1'b0;
                    if (num_q != 3'd0) begin
                        state_q  <= RUN;
                        cnt_q    <= pend_q - ONE;
                        active_q <= 1'b1;
                    end else begin
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        if (state_q == STOP && tone_q && num_q == 3'd0) begin
                            // a high half-period just ended with no note held: go silent
                            state_q   <= IDLE;
                            tone_q    <= 1'b0;
                            cnt_q     <= '0;
                            speaker_q <= 1'b0;
                            active_q  <= 1'b0;
                        end else begin
                            state_q   <= (num_q != 3'd0) ? RUN : STOP;
                            tone_q    <= ~tone_q;
                            cnt_q     <= pend_q - ONE;
                            speaker_q <= ~tone_q & en_s2_q;
                            active_q  <= 1'b1;
                        end
                    end else begin
                        state_q   <= (num_q != 3'd0) ? RUN : STOP;
                        cnt_q     <= cnt_q - ONE;
                        speaker_q <= tone_q & en_s2_q;
                        active_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign speaker_o  = speaker_q;
    assign num_show_o = num_q;
    assign oct_show_o = oct_q;
    assign active_o   = active_q;

endmodule

// File: tb/tb_organ_tone_gen.sv
// Directed bench for organ_tone_gen, run with a short debounce window.
module tb_organ_tone_gen;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] key;
    logic [1:0] octave;
    logic       enable;
    logic       speaker;
    logic [2:0] num_show;
    logic [1:0] oct_show;
    logic       active;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0] key;
        logic [1:0] oct;
        int         num;
        int         osh;
        int         half;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    organ_tone_gen #(.CNT_W(12), .DEB_CYCLES(DEB), .DEB_W(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_i      (key),
        .octave_i   (octave),
        .enable_i   (enable),
        .speaker_o  (speaker),
        .num_show_o (num_show),
        .oct_show_o (oct_show),
        .active_o   (active)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges until speaker reads v (capped at limit).
    task automatic until_spk(input logic v, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (speaker !== v && n < limit);
    endtask

    task automatic until_num(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (num_show === 3'd0 && n < limit);
    endtask

    task automatic until_idle(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (active !== 1'b0 && n < limit);
    endtask

    initial begin
        int n;
        int bad;

        tbl[0] = '{7'b0000001, 2'd1, 1, 1, 1908};
        tbl[1] = '{7'b0000101, 2'd1, 1, 1, 1908};
        tbl[2] = '{7'b0100000, 2'd0, 6, 0, 2272};
        tbl[3] = '{7'b0100000, 2'd2, 6, 2, 568};
        tbl[4] = '{7'b0100000, 2'd3, 6, 1, 1136};
        tbl[5] = '{7'b1000000, 2'd2, 7, 2, 506};
        tbl[6] = '{7'b0001000, 2'd0, 4, 0, 2866};
        tbl[7] = '{7'b1111110, 2'd1, 2, 1, 1701};

        // reset held with a key pressed: everything stays quiet
        rst_n  = 1'b0;
        key    = 7'b0000001;
        octave = 2'd1;
        enable = 1'b1;
        bad    = 0;
        repeat (20) begin
            tick(1);
            if ({speaker, num_show, oct_show, active} !== 8'd0) bad++;
        end
        chk("reset_hold_quiet", bad, 0);

        // release: display changes exactly DEB+3 edges later
        rst_n = 1'b1;
        tick(DEB + 2);
        chk("latency_before_num", int'(num_show), 0);
        chk("latency_before_spk", int'(speaker), 0);
        tick(1);
        chk("latency_num_do", int'(num_show), 1);
        chk("latency_oct_mid", int'(oct_show), 1);

        // middle do: first rise D+1 after display, then 1908/1908
        until_spk(1'b1, 5000, n);
        chk("do_first_rise", n, 1909);
        chk("do_active", int'(active), 1);
        until_spk(1'b0, 5000, n);
        chk("do_high", n, 1908);
        until_spk(1'b1, 5000, n);
        chk("do_low", n, 1908);

        // release 100 cycles into a high half: the half completes, then silence
        tick(100);
        key = 7'b0000000;
        until_spk(1'b0, 5000, n);
        chk("noteoff_high_rest", n, 1808);
        chk("noteoff_active_fall", int'(active), 0);
        chk("noteoff_num", int'(num_show), 0);

        // reset mid-tone forces the outputs low immediately
        key = 7'b0000001;
        until_spk(1'b1, 5000, n);
        chk("pre_reset_rise", int'(speaker), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", int'({speaker, num_show, oct_show, active}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(DEB + 2);
        chk("postreset_quiet_num", int'(num_show), 0);
        chk("postreset_quiet_spk", int'(speaker), 0);
        tick(1);
        chk("postreset_num", int'(num_show), 1);
        key = 7'b0000000;
        until_idle(10000, n);
        chk("postreset_idle", int'(active), 0);

        // bounce: 2-cycle toggles never get through the debouncer
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            key = (i % 2 == 0) ? 7'b0000100 : 7'b0000000;
            repeat (2) begin
                tick(1);
                if (num_show !== 3'd0 || speaker !== 1'b0) bad++;
            end
        end
        chk("bounce_quiet", bad, 0);
        key = 7'b0000100;
        tick(DEB + 2);
        chk("bounce_settle_before", int'(num_show), 0);
        tick(1);
        chk("bounce_settle_mi", int'(num_show), 3);

        // mi -> so in the middle of a high half: that half stays 1515
        until_spk(1'b1, 5000, n);
        chk("mi_first_rise", n, 1516);
        tick(500);
        key = 7'b0010000;
        until_spk(1'b0, 5000, n);
        chk("change_rest_of_mi", n, 1015);
        chk("change_num_so", int'(num_show), 5);
        until_spk(1'b1, 5000, n);
        chk("change_so_low", n, 1276);
        until_spk(1'b0, 5000, n);
        chk("change_so_high", n, 1276);

        // release during a low half: low completes, one more high half, then idle
        tick(100);
        key = 7'b0000000;
        until_spk(1'b1, 5000, n);
        chk("lowoff_rest", n, 1176);
        chk("lowoff_active_high", int'(active), 1);
        until_spk(1'b0, 5000, n);
        chk("lowoff_last_high", n, 1276);
        chk("lowoff_active_fall", int'(active), 0);

        // enable low mutes the pin only
        key = 7'b0000001;
        until_spk(1'b1, 5000, n);
        chk("en_first_rise", n, 1909 + DEB + 3);
        enable = 1'b0;
        tick(3);
        bad = 0;
        repeat (2000) begin
            tick(1);
            if (speaker !== 1'b0) bad++;
        end
        chk("en_muted", bad, 0);
        chk("en_num_kept", int'(num_show), 1);
        chk("en_active_kept", int'(active), 1);
        enable = 1'b1;
        key    = 7'b0000000;
        until_idle(10000, n);
        chk("en_idle", int'(active), 0);

        // table: press, check display and first rise, release at the rise, check the high half
        for (int v = 0; v < 8; v++) begin
            key    = tbl[v].key;
            octave = tbl[v].oct;
            until_num(50, n);
            chk($sformatf("vec%0d_num", v), int'(num_show), tbl[v].num);
            chk($sformatf("vec%0d_oct", v), int'(oct_show), tbl[v].osh);
            until_spk(1'b1, 8000, n);
            chk($sformatf("vec%0d_rise", v), n, tbl[v].half + 1);
            key = 7'b0000000;
            until_spk(1'b0, 8000, n);
            chk($sformatf("vec%0d_high", v), n, tbl[v].half);
            chk($sformatf("vec%0d_idle", v), int'(active), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
